multi_channel_frame_memory: RTL and testbench
=============================================

MULTI_CHANNEL_FRAME_MEMORY -- requirements
Module: multi_channel_frame_memory

Interface
REQ-001 SHALL have parameter CHANNELS, default 3, number of parallel pixel channels stored per location.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, bits per channel sample.
REQ-003 SHALL have parameter MAX_IMAGE_SIZE, default 512, maximum rows and columns.
REQ-004 SHALL have parameter MAX_IMAGE_SIZE_LOG2, default 9; all row/col ports are MAX_IMAGE_SIZE_LOG2+1 bits, two's-complement signed.
REQ-005 SHALL have ports: clk, input, 1, single clock for the whole block; all logic is on its rising edge.
REQ-006 SHALL have ports: rst, input, 1, asynchronous, active-high reset.
REQ-007 SHALL have ports: start, input, 1, begins loading a new frame.
REQ-008 SHALL have ports: img_rows and img_cols, input, MAX_IMAGE_SIZE_LOG2+1 each, active frame size; sampled on start; legal range 1..MAX_IMAGE_SIZE.
REQ-009 SHALL have ports: in_valid, input, 1; in_ready, output, 1; in_data, input, CHANNELS*DATA_WIDTH, raster-order write stream, channel 0 in the LSBs.
REQ-010 SHALL have ports: rd_en, input, 1; row_rd and col_rd, input, signed read address.
REQ-011 SHALL have ports: rd_valid, output, 1; rd_data, output, CHANNELS*DATA_WIDTH, read result.
REQ-012 SHALL have ports: frame_ready, output, 1, frame fully loaded and readable; busy, output, 1, load in progress.

Function
REQ-013 SHALL implement a state machine with states IDLE, LOAD and READY.
REQ-014 Transitions SHALL be: IDLE->LOAD on start; LOAD->READY on accepting the last pixel (row img_rows-1, col img_cols-1); READY->LOAD on start.
REQ-015 start SHALL be ignored while in LOAD.
REQ-016 On entering LOAD, the block SHALL latch img_rows/img_cols and clear the write row/col counters to 0.
REQ-017 in_ready SHALL be 1 only in LOAD; a pixel is accepted on any cycle with in_valid and in_ready both high.
REQ-018 On each accepted pixel, the block SHALL write all channels at (wr_row, wr_col), then increment wr_col.
REQ-019 When wr_col reaches img_cols-1, wr_col SHALL wrap to 0 and wr_row SHALL increment.
REQ-020 On the final pixel, in_ready SHALL deassert on the next cycle.
REQ-021 busy SHALL equal (state==LOAD).
REQ-022 frame_ready SHALL equal (state==READY).
REQ-023 Reads SHALL have fixed 1-cycle latency: rd_en at cycle N gives rd_valid=1 and rd_data at cycle N+1; rd_valid is 0 otherwise.
REQ-024 Reads SHALL be accepted in any state; reads of locations not yet written in the current frame return the stored (stale) contents.
REQ-025 Zero padding: if row_rd<0, row_rd>=img_rows, col_rd<0 or col_rd>=img_cols (latched sizes), rd_data SHALL be all zeros and the memory SHALL not be indexed.
REQ-026 Read and write to the same address in the same cycle SHALL return the old data (read-before-write).
REQ-027 rd_data SHALL hold its last value while rd_valid is 0.
REQ-028 A start with img_rows or img_cols equal to 0 or greater than MAX_IMAGE_SIZE SHALL be ignored; state is unchanged.

Reset
REQ-029 On asserted rst, the block SHALL immediately force: state=IDLE, counters=0, latched sizes=0, in_ready=0, rd_valid=0, rd_data=0, frame_ready=0, busy=0.
REQ-030 Memory contents SHALL NOT be reset.
REQ-031 Reset asserted in the middle of LOAD SHALL abandon the frame; a new start is required afterwards.

Structure
REQ-032 Package vt512_mem_pkg SHALL hold the state enum fm_state_t and the padding-zero constant.
REQ-033 Storage SHALL be one sub-module, frame_mem_bank (one write port, one registered read port, DATA_WIDTH x MAX_IMAGE_SIZE^2), instantiated CHANNELS times via generate.

Verification
REQ-034 Reset then start with 4x4 frame, stream values 0..15 with in_valid held high -> exactly 16 accepts, frame_ready=1 one cycle after the last accept, in_ready=0.
REQ-035 Read (2,3) after load -> rd_valid=1 the next cycle, rd_data=11 on every channel.
REQ-036 Read (-1,0), (4,2) and (0,4) on a 4x4 frame -> rd_data=0 with rd_valid=1.
REQ-037 Random in_valid gaps (50%) on a 3x5 frame -> counters wrap correctly; read (2,4) returns the 15th pixel.
REQ-038 Assert rst after 7 pixels of an 8x8 load -> all outputs zero immediately, state IDLE, in_ready=0 until the next start.
REQ-039 Same-cycle write and read of address (1,1) during a reload -> returns the previous frame's value.

Source files
------------

// File: rtl/vt512_mem_pkg.sv
// Shared types and constants for the multi-channel frame memory.
// Holds the load state machine encoding and the value used for padded reads.
package vt512_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2
    } fm_state_t;

    // Out-of-frame reads return this bit replicated across the whole pixel word.
    localparam logic PAD_BIT = 1'b0;

endpackage

// File: rtl/frame_mem_bank.sv
// One channel of frame storage: a single write port plus a registered read port.
// The read samples the array before the same-edge write lands, so a collision returns the old word.
module frame_mem_bank #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 18
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Contents are never reset so a stale frame survives until it is overwritten.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/multi_channel_frame_memory.sv
// Frame buffer that loads a raster stream into per-channel banks and serves
// random-access reads with zero padding outside the latched frame size.
module multi_channel_frame_memory
    import vt512_mem_pkg::*;
#(
    parameter int CHANNELS            = 3,
    parameter int DATA_WIDTH          = 8,
    parameter int MAX_IMAGE_SIZE      = 512,
    parameter int MAX_IMAGE_SIZE_LOG2 = 9
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic signed [MAX_IMAGE_SIZE_LOG2:0] img_rows,
    input  logic signed [MAX_IMAGE_SIZE_LOG2:0] img_cols,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [CHANNELS*DATA_WIDTH-1:0]      in_data,
    input  logic                                rd_en,
    input  logic signed [MAX_IMAGE_SIZE_LOG2:0] row_rd,
    input  logic signed [MAX_IMAGE_SIZE_LOG2:0] col_rd,
    output logic                                rd_valid,
    output logic [CHANNELS*DATA_WIDTH-1:0]      rd_data,
    output logic                                frame_ready,
    output logic                                busy
);

    localparam int LW     = MAX_IMAGE_SIZE_LOG2;
    localparam int W      = MAX_IMAGE_SIZE_LOG2 + 1;
    localparam int AW     = 2 * MAX_IMAGE_SIZE_LOG2;
    localparam int DW_ALL = CHANNELS * DATA_WIDTH;
    localparam logic [W-1:0] MAX_SZ = W'(MAX_IMAGE_SIZE);

    fm_state_t       state_q, state_d;
    logic [W-1:0]    imgRows_q, imgRows_d;
    logic [W-1:0]    imgCols_q, imgCols_d;
    logic [LW-1:0]   wrRow_q, wrRow_d;
    logic [LW-1:0]   wrCol_q, wrCol_d;
    logic            rdValid_q;
    logic            rdZero_q;

    logic            sizeOk;
    logic            accept;
    logic            lastCol;
    logic            lastRow;
    logic            rowIn;
    logic            colIn;
    logic            rdHit;
    logic [AW-1:0]   wrAddr;
    logic [AW-1:0]   rdAddr;
    logic [DW_ALL-1:0] bankData;

    // Frame sizes are treated as unsigned so the full 1..MAX_IMAGE_SIZE range is representable.
    assign sizeOk = ($unsigned(img_rows) != '0) && ($unsigned(img_cols) != '0) &&
                    ($unsigned(img_rows) <= MAX_SZ) && ($unsigned(img_cols) <= MAX_SZ);

    assign in_ready    = (state_q == LOAD);
    assign busy        = (state_q == LOAD);
    assign frame_ready = (state_q == READY);
    assign accept      = in_valid && in_ready;

    assign lastCol = ({1'b0, wrCol_q} == (imgCols_q - W'(1)));
    assign lastRow = ({1'b0, wrRow_q} == (imgRows_q - W'(1)));

    always_comb begin
        state_d   = state_q;
        imgRows_d = imgRows_q;
        imgCols_d = imgCols_q;
        wrRow_d   = wrRow_q;
        wrCol_d   = wrCol_q;
        case (state_q)
            IDLE, READY: begin
                if (start && sizeOk) begin
                    state_d   = LOAD;
                    imgRows_d = $unsigned(img_rows);
                    imgCols_d = $unsigned(img_cols);
                    wrRow_d   = '0;
                    wrCol_d   = '0;
                end
            end
            LOAD: begin
                if (accept) begin
                    if (lastCol) begin
                        wrCol_d = '0;
                        if (lastRow) begin
                            state_d = READY;
                        end else begin
                            wrRow_d = wrRow_q + LW'(1);
                        end
                    end else begin
                        wrCol_d = wrCol_q + LW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            imgRows_q <= '0;
            imgCols_q <= '0;
            wrRow_q   <= '0;
            wrCol_q   <= '0;
        end else begin
            state_q   <= state_d;
            imgRows_q <= imgRows_d;
            imgCols_q <= imgCols_d;
            wrRow_q   <= wrRow_d;
            wrCol_q   <= wrCol_d;
        end
    end

    // Negative coordinates are caught by the sign bit before the unsigned bound check.
    assign rowIn  = !row_rd[W-1] && ($unsigned(row_rd) < imgRows_q);
    assign colIn  = !col_rd[W-1] && ($unsigned(col_rd) < imgCols_q);
    assign rdHit  = rowIn && colIn;
    assign wrAddr = {wrRow_q, wrCol_q};
    assign rdAddr = {row_rd[LW-1:0], col_rd[LW-1:0]};

    // rdZero_q only changes on a read, so a padded result holds just like a bank result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdValid_q <= 1'b0;
            rdZero_q  <= 1'b1;
        end else begin
            rdValid_q <= rd_en;
            if (rd_en) begin
                rdZero_q <= !rdHit;
            end
        end
    end

    assign rd_valid = rdValid_q;
    assign rd_data  = rdZero_q ? {DW_ALL{PAD_BIT}} : bankData;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_bank
        frame_mem_bank #(
            .DATA_WIDTH(DATA_WIDTH),
            .ADDR_WIDTH(AW)
        ) u_bank (
            .clk  (clk),
            .we   (accept),
            .waddr(wrAddr),
            .wdata(in_data[c*DATA_WIDTH +: DATA_WIDTH]),
            .re   (rd_en && rdHit),
            .raddr(rdAddr),
            .rdata(bankData[c*DATA_WIDTH +: DATA_WIDTH])
        );
    end

endmodule

// File: tb/tb_multi_channel_frame_memory.sv
// Directed bench for multi_channel_frame_memory: loads, padded reads,
// collisions and mid-load reset, all checked against hand-computed values.
module tb_multi_channel_frame_memory;

    logic              clk;
    logic              rst;
    logic              start;
    logic signed [9:0] img_rows;
    logic signed [9:0] img_cols;
    logic              in_valid;
    logic              in_ready;
    logic [23:0]       in_data;
    logic              rd_en;
    logic signed [9:0] row_rd;
    logic signed [9:0] col_rd;
    logic              rd_valid;
    logic [23:0]       rd_data;
    logic              frame_ready;
    logic              busy;

    int checks   = 0;
    int failures = 0;

    multi_channel_frame_memory dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .img_rows   (img_rows),
        .img_cols   (img_cols),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .rd_en      (rd_en),
        .row_rd     (row_rd),
        .col_rd     (col_rd),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .frame_ready(frame_ready),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Channel c of pixel p carries base + p + c*step.
    function automatic logic [23:0] pixWord(input logic [7:0] base, input logic [7:0] step, input int p);
        logic [7:0] v;
        v = base + 8'(p);
        return {v + step + step, v + step, v};
    endfunction

    task automatic startFrame(input int rows, input int cols);
        start    = 1'b1;
        img_rows = 10'(rows);
        img_cols = 10'(cols);
        tick();
        start    = 1'b0;
    endtask

    task automatic readPixel(input int r, input int c);
        rd_en  = 1'b1;
        row_rd = 10'(r);
        col_rd = 10'(c);
        tick();
        rd_en  = 1'b0;
    endtask

    // Streams nPix pixels; optionally issues a read of (cRow,cCol) alongside pixel collideIdx.
    task automatic applyStimulus(input int nPix, input logic [7:0] base, input logic [7:0] step,
                                 input bit gaps, input int collideIdx, input int cRow, input int cCol,
                                 output int accepts, output logic [23:0] collideData);
        int  p;
        int  cyc;
        bit  took;
        bit  didRead;
        p           = 0;
        cyc         = 0;
        accepts     = 0;
        collideData = '0;
        while (p < nPix && cyc < 300) begin
            in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = pixWord(base, step, p);
            didRead  = (p == collideIdx) && in_valid && in_ready;
            rd_en    = didRead;
            if (didRead) begin
                row_rd = 10'(cRow);
                col_rd = 10'(cCol);
            end
            took = in_valid && in_ready;
            tick();
            if (took) begin
                p++;
                accepts++;
            end
            if (didRead) begin
                collideData = rd_data;
            end
            cyc++;
        end
        in_valid = 1'b0;
        rd_en    = 1'b0;
    endtask

    initial begin
        int          acc;
        logic [23:0] cdata;

        rst      = 1'b1;
        start    = 1'b0;
        img_rows = '0;
        img_cols = '0;
        in_valid = 1'b0;
        in_data  = '0;
        rd_en    = 1'b0;
        row_rd   = '0;
        col_rd   = '0;

        tick();
        tick();
        checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_frame_ready", 32'(frame_ready), 32'd0);
        checkOutput("reset_rd_valid", 32'(rd_valid), 32'd0);
        checkOutput("reset_rd_data", 32'(rd_data), 32'd0);
        rst = 1'b0;
        tick();

        $display("[TB] 4x4 load of values 0..15");
        startFrame(4, 4);
        checkOutput("load4_busy", 32'(busy), 32'd1);
        checkOutput("load4_in_ready", 32'(in_ready), 32'd1);
        applyStimulus(16, 8'h00, 8'h00, 1'b0, -1, 0, 0, acc, cdata);
        checkOutput("load4_accepts", 32'(acc), 32'd16);
        checkOutput("load4_frame_ready", 32'(frame_ready), 32'd1);
        checkOutput("load4_in_ready_done", 32'(in_ready), 32'd0);
        checkOutput("load4_busy_done", 32'(busy), 32'd0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checkOutput("load4_extra_valid_ignored", 32'(frame_ready), 32'd1);

        readPixel(2, 3);
        checkOutput("rd23_valid", 32'(rd_valid), 32'd1);
        checkOutput("rd23_data", 32'(rd_data), 32'h0B0B0B);
        tick();
        checkOutput("rd23_valid_drop", 32'(rd_valid), 32'd0);
        checkOutput("rd23_data_hold", 32'(rd_data), 32'h0B0B0B);
        readPixel(3, 3);
        checkOutput("rd33_data", 32'(rd_data), 32'h0F0F0F);
        readPixel(-1, 0);
        checkOutput("pad_m1_0_valid", 32'(rd_valid), 32'd1);
        checkOutput("pad_m1_0_data", 32'(rd_data), 32'd0);
        readPixel(3, 3);
        readPixel(4, 2);
        checkOutput("pad_4_2_data", 32'(rd_data), 32'd0);
        readPixel(3, 3);
        readPixel(0, 4);
        checkOutput("pad_0_4_valid", 32'(rd_valid), 32'd1);
        checkOutput("pad_0_4_data", 32'(rd_data), 32'd0);

        $display("[TB] illegal frame sizes from READY");
        startFrame(0, 4);
        checkOutput("start_rows0_ignored", 32'(frame_ready), 32'd1);
        startFrame(4, 513);
        checkOutput("start_cols513_ignored", 32'(frame_ready), 32'd1);

        $display("[TB] 3x5 load with random valid gaps");
        startFrame(3, 5);
        applyStimulus(15, 8'h60, 8'h20, 1'b1, -1, 0, 0, acc, cdata);
        checkOutput("load35_accepts", 32'(acc), 32'd15);
        checkOutput("load35_frame_ready", 32'(frame_ready), 32'd1);
        readPixel(2, 4);
        checkOutput("rd24_data", 32'(rd_data), 32'hAE8E6E);
        readPixel(1, 0);
        checkOutput("rd10_wrap_data", 32'(rd_data), 32'hA58565);
        readPixel(0, 4);
        checkOutput("rd04_data", 32'(rd_data), 32'hA48464);
        readPixel(2, 5);
        checkOutput("pad_2_5_data", 32'(rd_data), 32'd0);

        $display("[TB] reload 4x4 with same-cycle read of (1,1)");
        startFrame(4, 4);
        applyStimulus(16, 8'hC0, 8'h10, 1'b0, 5, 1, 1, acc, cdata);
        checkOutput("reload_accepts", 32'(acc), 32'd16);
        checkOutput("collide_old_data", 32'(cdata), 32'hA68666);
        readPixel(1, 1);
        checkOutput("collide_new_data", 32'(rd_data), 32'hE5D5C5);

        $display("[TB] 8x8 load interrupted by reset");
        startFrame(8, 8);
        applyStimulus(7, 8'h10, 8'h01, 1'b0, -1, 0, 0, acc, cdata);
        checkOutput("load88_partial_accepts", 32'(acc), 32'd7);
        startFrame(2, 2);
        checkOutput("start_in_load_busy", 32'(busy), 32'd1);
        readPixel(0, 2);
        checkOutput("load88_rd02_valid", 32'(rd_valid), 32'd1);
        checkOutput("load88_rd02_data", 32'(rd_data), 32'h141312);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("midrst_frame_ready", 32'(frame_ready), 32'd0);
        checkOutput("midrst_rd_valid", 32'(rd_valid), 32'd0);
        checkOutput("midrst_rd_data", 32'(rd_data), 32'd0);
        tick();
        rst = 1'b0;
        in_valid = 1'b1;
        tick();
        tick();
        checkOutput("postrst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("postrst_busy", 32'(busy), 32'd0);
        checkOutput("postrst_rd_data", 32'(rd_data), 32'd0);
        in_valid = 1'b0;
        startFrame(2, 2);
        checkOutput("restart_busy", 32'(busy), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
